// File: rtl/systolic_feed_controller.sv
// Sequencer for one systolic-array pass: weight preload, activation streaming, skew drain.
// Optional stall-cycle counter is built when FEED_CTRL_PERF_CNT_EN is defined.
module systolic_feed_controller #(
    parameter int unsigned SYS_ROWS = 4,
    parameter int unsigned SYS_COLS = 4,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned TILE_W   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [LEN_W-1:0]                        cfg_len,
    input  logic [TILE_W-1:0]                       cfg_tiles,
    input  logic                                    out_ready,
    output logic                                    buf_read,
    output logic                                    w_load,
    output logic [((SYS_ROWS > 1) ? $clog2(SYS_ROWS) : 1)-1:0] w_row,
    output logic                                    acc_clear,
    output logic [TILE_W-1:0]                       tile_idx,
    output logic                                    busy,
    output logic                                    done,
    output logic [31:0]                             perf_cycles
);

    localparam int unsigned ROW_W     = (SYS_ROWS > 1) ? $clog2(SYS_ROWS) : 1;
    localparam int unsigned DRAIN_CYC = SYS_ROWS + SYS_COLS - 1;
    localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [TILE_W-1:0]   tiles_q, tiles_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [LEN_W-1:0]    vec_q, vec_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [ROW_W-1:0]    w_row_q, w_row_d;
    logic                buf_read_q, buf_read_d;
    logic                w_load_q, w_load_d;
    logic                acc_clear_q, acc_clear_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        tiles_d     = tiles_q;
        tile_d      = tile_q;
        vec_d       = vec_q;
        drain_d     = drain_q;
        w_row_d     = '0;
        buf_read_d  = 1'b0;
        w_load_d    = 1'b0;
        acc_clear_d = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = cfg_len;
                    tiles_d = cfg_tiles;
                    tile_d  = '0;
                    if (cfg_len == '0 || cfg_tiles == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StLoadW;
                        w_load_d = 1'b1;
                    end
                end
            end
            StLoadW: begin
                if (w_row_q == ROW_W'(SYS_ROWS - 1)) begin
                    // The first read strobe is issued alongside the clear pulse.
                    state_d     = StStream;
                    acc_clear_d = 1'b1;
                    buf_read_d  = out_ready;
                    vec_d       = LEN_W'(out_ready);
                end else begin
                    w_load_d = 1'b1;
                    w_row_d  = w_row_q + ROW_W'(1);
                end
            end
            StStream: begin
                // vec_q counts strobes already issued; stop once the last one is on the wire.
                if (vec_q == len_q) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    buf_read_d = out_ready;
                    vec_d      = vec_q + LEN_W'(out_ready);
                end
            end
            StDrain: begin
                if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                    if (tile_q == tiles_q - TILE_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StLoadW;
                        tile_d   = tile_q + TILE_W'(1);
                        w_load_d = 1'b1;
                    end
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            tiles_q     <= '0;
            tile_q      <= '0;
            vec_q       <= '0;
            drain_q     <= '0;
            w_row_q     <= '0;
            buf_read_q  <= 1'b0;
            w_load_q    <= 1'b0;
            acc_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            tiles_q     <= tiles_d;
            tile_q      <= tile_d;
            vec_q       <= vec_d;
            drain_q     <= drain_d;
            w_row_q     <= w_row_d;
            buf_read_q  <= buf_read_d;
            w_load_q    <= w_load_d;
            acc_clear_q <= acc_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef FEED_CTRL_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == StIdle && start) begin
            perf_d = '0;
        end else if (state_q == StStream && !out_ready && perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

    assign buf_read  = buf_read_q;
    assign w_load    = w_load_q;
    assign w_row     = w_row_q;
    assign acc_clear = acc_clear_q;
    assign tile_idx  = tile_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Self-checking bench for systolic_feed_controller: per-cycle trace compared against a
// job-level schedule model built from out_ready patterns.
module tb_systolic_feed_controller;

    localparam int R    = 4;
    localparam int C    = 4;
    localparam int MAXC = 600;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [15:0] cfg_len;
    logic [7:0]  cfg_tiles;
    logic        buf_read, w_load, acc_clear, busy, done;
    logic [1:0]  w_row;
    logic [7:0]  tile_idx;
    logic [31:0] perf_cycles;

    int checks = 0;
    int errors = 0;

    // {busy, w_load, w_row[1:0], acc_clear, buf_read, done, tile_idx[7:0]}
    typedef logic [14:0] trace_t;

    bit          or_arr   [MAXC+1];
    trace_t      exp_tr   [MAXC+1];
    trace_t      obs_tr   [MAXC+1];
    logic [31:0] exp_perf [MAXC+1];
    logic [31:0] obs_perf [MAXC+1];
    int          n_cyc;

    systolic_feed_controller #(
        .SYS_ROWS (R),
        .SYS_COLS (C),
        .LEN_W    (16),
        .TILE_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_tiles   (cfg_tiles),
        .out_ready   (out_ready),
        .buf_read    (buf_read),
        .w_load      (w_load),
        .w_row       (w_row),
        .acc_clear   (acc_clear),
        .tile_idx    (tile_idx),
        .busy        (busy),
        .done        (done),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    function automatic trace_t mk(bit b, bit wl, int row, bit ac, bit br, bit dn, int t);
        return {b, wl, 2'(row), ac, br, dn, 8'(t)};
    endfunction

    function automatic int count_bit(int pos);
        int n = 0;
        for (int c = 1; c <= n_cyc; c++) n += int'(obs_tr[c][pos]);
        return n;
    endfunction

    function automatic int first_done();
        for (int c = 1; c <= n_cyc; c++) if (obs_tr[c][8]) return c;
        return -1;
    endfunction

    // Expected schedule: cycle c is the cycle after the c-th rising edge following start.
    task automatic build_model(input int len, input int tiles);
        int c    = 1;
        int perf = 0;
        int reads;
        bit br;
        for (int i = 0; i <= MAXC; i++) begin
            exp_tr[i]   = '0;
            exp_perf[i] = '0;
        end
        if (len == 0 || tiles == 0) begin
            exp_tr[1] = mk(1, 0, 0, 0, 0, 0, 0);
            exp_tr[2] = mk(0, 0, 0, 0, 0, 1, 0);
            exp_tr[3] = mk(0, 0, 0, 0, 0, 0, 0);
            n_cyc = 3;
            return;
        end
        for (int t = 0; t < tiles; t++) begin
            for (int r = 0; r < R; r++) begin
                exp_perf[c] = perf;
                exp_tr[c]   = mk(1, 1, r, 0, 0, 0, t);
                c++;
            end
            reads = 0;
            do begin
                // A read appears one cycle after out_ready was high.
                br          = or_arr[c-1];
                exp_perf[c] = perf;
                exp_tr[c]   = mk(1, 0, 0, reads == 0 && exp_tr[c-1][13], br, 0, t);
`ifdef FEED_CTRL_PERF_CNT_EN
                if (!or_arr[c]) perf++;
`endif
                reads += int'(br);
                c++;
            end while (reads < len && c < MAXC - R - C - 4);
            for (int d = 0; d < R + C - 1; d++) begin
                exp_perf[c] = perf;
                exp_tr[c]   = mk(1, 0, 0, 0, 0, 0, t);
                c++;
            end
        end
        exp_perf[c] = perf; exp_tr[c] = mk(1, 0, 0, 0, 0, 0, tiles - 1); c++;
        exp_perf[c] = perf; exp_tr[c] = mk(0, 0, 0, 0, 0, 1, tiles - 1); c++;
        exp_perf[c] = perf; exp_tr[c] = mk(0, 0, 0, 0, 0, 0, tiles - 1);
        n_cyc = c;
    endtask

    // Drives one job and records the DUT trace; ign > 0 pulses a stray start at that cycle.
    task automatic run_job(input int len, input int tiles, input int ign);
        cfg_len   = 16'(len);
        cfg_tiles = 8'(tiles);
        start     = 1'b1;
        out_ready = or_arr[0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= n_cyc; c++) begin
            obs_tr[c]   = {busy, w_load, w_row, acc_clear, buf_read, done, tile_idx};
            obs_perf[c] = perf_cycles;
            out_ready   = or_arr[c];
            cfg_len     = 16'($urandom_range(0, 20));
            cfg_tiles   = 8'($urandom_range(0, 5));
            start       = (c == ign);
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic fill_ready(input int pct);
        for (int i = 0; i <= MAXC; i++) or_arr[i] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; cfg_len = '0; cfg_tiles = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, w_load, w_row, acc_clear, buf_read, done, tile_idx} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {busy, w_load, w_row, acc_clear,
                     buf_read, done, tile_idx});
        end
        checks++;
        if (perf_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d want 0", perf_cycles);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_tile();
        fill_ready(100);
        build_model(8, 1);
        run_job(8, 1, 0);
        for (int c = 1; c <= n_cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c] || obs_perf[c] !== exp_perf[c]) begin
                errors++;
                $display("FAIL single_tile cyc %0d: got %b/%0d want %b/%0d", c, obs_tr[c],
                         obs_perf[c], exp_tr[c], exp_perf[c]);
            end
        end
        checks++;
        if (first_done() != 21) begin
            errors++;
            $display("FAIL single_tile_done_cycle: got %0d want 21", first_done());
        end
        checks++;
        if (count_bit(9) != 8 || count_bit(13) != 4 || count_bit(10) != 1) begin
            errors++;
            $display("FAIL single_tile_counts: reads %0d wload %0d clr %0d want 8 4 1",
                     count_bit(9), count_bit(13), count_bit(10));
        end
    endtask

    task automatic test_three_tiles();
        fill_ready(100);
        build_model(3, 3);
        run_job(3, 3, 0);
        for (int c = 1; c <= n_cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c] || obs_perf[c] !== exp_perf[c]) begin
                errors++;
                $display("FAIL three_tiles cyc %0d: got %b/%0d want %b/%0d", c, obs_tr[c],
                         obs_perf[c], exp_tr[c], exp_perf[c]);
            end
        end
        checks++;
        if (count_bit(9) != 9 || count_bit(10) != 3 || count_bit(8) != 1) begin
            errors++;
            $display("FAIL three_tiles_counts: reads %0d clr %0d done %0d want 9 3 1",
                     count_bit(9), count_bit(10), count_bit(8));
        end
    endtask

    task automatic test_backpressure();
        fill_ready(100);
        // Reads land in cycles 5 and 6; out_ready low in cycles 6..10.
        for (int i = 6; i <= 10; i++) or_arr[i] = 1'b0;
        build_model(6, 1);
        run_job(6, 1, 0);
        for (int c = 1; c <= n_cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c] || obs_perf[c] !== exp_perf[c]) begin
                errors++;
                $display("FAIL backpressure cyc %0d: got %b/%0d want %b/%0d", c, obs_tr[c],
                         obs_perf[c], exp_tr[c], exp_perf[c]);
            end
        end
        checks++;
        if (count_bit(9) != 6 || count_bit(10) != 1 || first_done() != 24) begin
            errors++;
            $display("FAIL backpressure_counts: reads %0d clr %0d done@%0d want 6 1 24",
                     count_bit(9), count_bit(10), first_done());
        end
        checks++;
`ifdef FEED_CTRL_PERF_CNT_EN
        if (obs_perf[n_cyc] !== 32'd5) begin
            errors++;
            $display("FAIL backpressure_perf: got %0d want 5", obs_perf[n_cyc]);
        end
`else
        if (obs_perf[n_cyc] !== 32'd0) begin
            errors++;
            $display("FAIL backpressure_perf: got %0d want 0", obs_perf[n_cyc]);
        end
`endif
    endtask

    task automatic test_degenerate();
        int lens  [2] = '{0, 5};
        int tiles [2] = '{2, 0};
        for (int k = 0; k < 2; k++) begin
            fill_ready(100);
            build_model(lens[k], tiles[k]);
            run_job(lens[k], tiles[k], 0);
            for (int c = 1; c <= n_cyc; c++) begin
                checks++;
                if (obs_tr[c] !== exp_tr[c] || obs_perf[c] !== exp_perf[c]) begin
                    errors++;
                    $display("FAIL degenerate%0d cyc %0d: got %b/%0d want %b/%0d", k, c,
                             obs_tr[c], obs_perf[c], exp_tr[c], exp_perf[c]);
                end
            end
            checks++;
            if (first_done() != 2 || count_bit(9) != 0 || count_bit(13) != 0) begin
                errors++;
                $display("FAIL degenerate%0d_summary: done@%0d reads %0d wload %0d want 2 0 0",
                         k, first_done(), count_bit(9), count_bit(13));
            end
        end
    endtask

    task automatic test_ignored_start();
        fill_ready(100);
        build_model(4, 2);
        run_job(4, 2, 3);
        for (int c = 1; c <= n_cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c] || obs_perf[c] !== exp_perf[c]) begin
                errors++;
                $display("FAIL ignored_start cyc %0d: got %b/%0d want %b/%0d", c, obs_tr[c],
                         obs_perf[c], exp_tr[c], exp_perf[c]);
            end
        end
        checks++;
        if (count_bit(8) != 1) begin
            errors++;
            $display("FAIL ignored_start_done_count: got %0d want 1", count_bit(8));
        end
    endtask

    task automatic test_reset_mid_job();
        int dn = 0;
        cfg_len = 16'd8; cfg_tiles = 8'd1; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (buf_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_streaming: got read %b busy %b want 1 1", buf_read, busy);
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, w_load, w_row, acc_clear, buf_read, done, tile_idx} !== 15'd0 ||
                perf_cycles !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_outputs%0d: got %b perf %0d want 0", k,
                         {busy, w_load, w_row, acc_clear, buf_read, done, tile_idx}, perf_cycles);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            dn += int'(done) + int'(busy);
            @(posedge clk); #1;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d busy/done cycles want 0", dn);
        end
        fill_ready(100);
        build_model(3, 1);
        run_job(3, 1, 0);
        for (int c = 1; c <= n_cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c] || obs_perf[c] !== exp_perf[c]) begin
                errors++;
                $display("FAIL reset_mid_restart cyc %0d: got %b/%0d want %b/%0d", c, obs_tr[c],
                         obs_perf[c], exp_tr[c], exp_perf[c]);
            end
        end
    endtask

    task automatic test_random();
        int len, tiles;
        for (int j = 0; j < 20; j++) begin
            len   = $urandom_range(1, 7);
            tiles = $urandom_range(1, 3);
            fill_ready(70);
            build_model(len, tiles);
            run_job(len, tiles, (j % 3 == 0) ? 2 : 0);
            for (int c = 1; c <= n_cyc; c++) begin
                checks++;
                if (obs_tr[c] !== exp_tr[c] || obs_perf[c] !== exp_perf[c]) begin
                    errors++;
                    $display("FAIL random%0d K=%0d T=%0d cyc %0d: got %b/%0d want %b/%0d", j,
                             len, tiles, c, obs_tr[c], obs_perf[c], exp_tr[c], exp_perf[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_three_tiles();
        test_backpressure();
        test_degenerate();
        test_ignored_start();
        test_reset_mid_job();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feed_controller.md
# systolic_feed_controller

Sequencer for one systolic-array pass: preloads the weight rows, then streams activation vectors by driving the input buffer's `read` strobe, then flushes the array skew before the next tile. It sits between the host/config logic and the input buffer, weight loader and output accumulators. It also gates streaming on output-side backpressure and handles multi-tile jobs with a start/done handshake.

## Interface
- `SYS_ROWS`, 4, array rows. Also the weight-load length and the depth of the input-skew chain.
- `SYS_COLS`, 4, array columns. Used in the drain length.
- `LEN_W`, 16, width of the vector-count fields.
- `TILE_W`, 8, width of the tile-count fields.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  job request, single-cycle pulse; sampled only in IDLE.
- `cfg_len`  in  LEN_W  activation vectors per tile (K); latched on accepted `start`.
- `cfg_tiles`  in  TILE_W  tiles per job; latched on accepted `start`.
- `out_ready`  in  1  output side can accept results; low stalls streaming.
- `buf_read`  out  1  read strobe to the input buffer (row 0 of the skew chain).
- `w_load`  out  1  weight-row load enable.
- `w_row`  out  $clog2(SYS_ROWS)  weight row being loaded.
- `acc_clear`  out  1  accumulator clear pulse at the start of each tile.
- `tile_idx`  out  TILE_W  current tile number, 0-based.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `perf_cycles`  out  32  stall-cycle counter (see Configuration).

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE. One-hot or binary encoding is implementer's choice.
- **IDLE**
  - On `start`: latch `cfg_len` and `cfg_tiles`, clear `tile_idx`.
  - If either latched value is 0, go to DONE. Otherwise go to LOAD_W.
- **LOAD_W**
  - `w_load`=1 for exactly SYS_ROWS cycles.
  - `w_row` counts 0..SYS_ROWS-1.
  - Then go to STREAM.
- **STREAM**
  - `acc_clear`=1 on the first STREAM cycle of each tile only.
  - `buf_read` = `out_ready`; the vector counter increments only when `buf_read`=1.
  - After `cfg_len` reads, go to DRAIN.
  - `out_ready` low holds the state and the counter. `acc_clear` is not re-issued on stall.
- **DRAIN**
  - Wait SYS_ROWS+SYS_COLS-1 cycles so the skewed valid chain and the array empty.
  - If `tile_idx` == latched tiles-1, go to DONE. Otherwise increment `tile_idx` and go to LOAD_W.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- Reaching the vector count uses an equality compare against the latched `cfg_len`. Counters are LEN_W wide, so `cfg_len` = 2^LEN_W-1 is legal.
- `start` outside IDLE is ignored. Config changes mid-job have no effect.
- `rst` mid-job returns to IDLE on the next edge and drops all outputs immediately (registered). No `done` is issued for the aborted job.

## Timing
- All outputs are registered. Reset values: `buf_read`, `w_load`, `acc_clear`, `busy` and `done` = 0; `w_row`, `tile_idx` and `perf_cycles` = 0.
- Example with `start` accepted at edge 0:
  - `busy` and `w_load` high in cycles 1..SYS_ROWS.
  - `acc_clear` and the first possible `buf_read` in cycle SYS_ROWS+1.
- One tile with no stalls: SYS_ROWS + K + SYS_ROWS + SYS_COLS - 1 cycles, then one DONE cycle.
- `out_ready` is sampled combinationally into the `buf_read` register. A stall therefore takes effect one cycle after `out_ready` falls, and the output side must tolerate one extra vector in flight.
- Zero-length job: `done` in cycle 2 after `start`, with `busy` high in cycle 1 only.

## Configuration
- Macro `FEED_CTRL_PERF_CNT_EN`.
- **Defined**: `perf_cycles` increments every cycle in STREAM with `out_ready`=0. It saturates at 2^32-1, clears on `rst`, and clears on each accepted `start`.
- **Undefined**: no counter logic is built and `perf_cycles` is tied to 0.

## Test plan
- **Reset mid-job**: hold `rst` for 2 cycles during STREAM -> next cycle all outputs 0, `busy`=0, no `done`, and a fresh `start` works.
- **Single tile**: SYS_ROWS=4, SYS_COLS=4, K=8, tiles=1, `out_ready`=1 -> `w_load` for 4 cycles, `acc_clear` once, 8 contiguous `buf_read` cycles, 7 drain cycles, `done` at cycle 21.
- **Three tiles**: K=3, tiles=3 -> `tile_idx` steps 0,1,2; 3 `acc_clear` pulses; 9 total `buf_read`; a single `done`.
- **Backpressure**: K=6, drop `out_ready` for 5 cycles after 2 reads -> exactly 6 reads total, no `acc_clear` repeat, `done` 5 cycles later than the unstalled run. With `FEED_CTRL_PERF_CNT_EN` defined, `perf_cycles`=5.
- **Degenerate and ignored starts**: `cfg_len`=0 -> `done` 2 cycles after `start` with zero `buf_read`/`w_load`. A second `start` pulsed while busy -> ignored; exactly one `done`.
